// File: rtl/cnt_sched_pkg.sv
// Shared types for the counter scheduler: command encoding and FSM states.
// Optional build macro: CNT_SCHED_SATURATE_EN (see counter_scheduler.sv).
package cnt_sched_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_UP   = 2'b10,
        CMD_DOWN = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side command bus of the counter scheduler.
// One valid/ready pair per requester plus packed command and argument.
interface counter_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_cmd;
    logic [WIDTH*NREQ-1:0] req_arg;

    modport master (
        output req_valid,
        output req_cmd,
        output req_arg,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_arg,
        output req_ready
    );
endinterface

// File: rtl/cnt_core.sv
// WIDTH-bit up/down counter; load overrides enable, wraps modulo 2^WIDTH.
// Synchronous active-high reset clears the count.
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, else step by one in the chosen direction.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = up_down ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one counter among NREQ requesters.
// Macro CNT_SCHED_SATURATE_EN: UP/DOWN stop at the bounds and flag done_sat.
module counter_scheduler
    import cnt_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    counter_scheduler_if.slave      io,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    done,
    output logic                    done_sat,
    output logic [WIDTH-1:0]        count
);
    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   own_q, own_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic             hs;
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_load;

`ifdef CNT_SCHED_SATURATE_EN
    localparam logic [WIDTH-1:0] MAXV = '1;
    logic sat_q, sat_d;
    logic at_bound;
    logic near_bound;

    assign at_bound = cnt_up ? (count == MAXV) : (count == '0);
    assign near_bound = cnt_up ? (count == MAXV - 1'b1)
                               : (count == WIDTH'(1));
`endif

    // Pick the first valid requester at or after the pointer.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && io.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign hs = (state_q == ST_IDLE) && win_found && !rst;
    assign io.req_ready = hs ? (NREQ'(1) << win_id) : '0;

    // FSM next state, command capture and counter control.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        arg_d    = arg_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        cnt_en   = 1'b0;
        cnt_up   = (cmd_q == CMD_UP);
        cnt_load = 1'b0;
`ifdef CNT_SCHED_SATURATE_EN
        sat_d    = sat_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_EXEC;
                    cmd_d   = cmd_e'(io.req_cmd[2*int'(win_id) +: 2]);
                    arg_d   = io.req_arg[WIDTH*int'(win_id) +: WIDTH];
                    own_d   = win_id;
                    ptr_d   = (win_id == IDW'(NREQ-1)) ? '0
                                                       : win_id + 1'b1;
`ifdef CNT_SCHED_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                if (cmd_q == CMD_LOAD) begin
                    cnt_load = 1'b1;
                end else if (cmd_q inside {CMD_UP, CMD_DOWN}
                             && arg_q != '0) begin
`ifdef CNT_SCHED_SATURATE_EN
                    if (at_bound) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        arg_d  = arg_q - 1'b1;
                        if (arg_q != WIDTH'(1)) begin
                            if (near_bound) begin
                                sat_d = 1'b1;
                            end else begin
                                state_d = ST_EXEC;
                            end
                        end
                    end
`else
                    cnt_en = 1'b1;
                    arg_d  = arg_q - 1'b1;
                    if (arg_q != WIDTH'(1)) begin
                        state_d = ST_EXEC;
                    end
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner, pointer and step-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            arg_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

`ifdef CNT_SCHED_SATURATE_EN
    // Bound-hit flag for the command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign done_sat = sat_q && (state_q == ST_DONE);
`else
    assign done_sat = 1'b0;
`endif

    assign busy     = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign grant_id = own_q;

    cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .enable    (cnt_en),
        .up_down   (cnt_up),
        .load      (cnt_load),
        .load_value(arg_q),
        .count     (count)
    );
endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, counter and argument width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester command valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester command accept, one-hot or zero.
REQ-007 SHALL have port req_cmd  input  2*NREQ  packed commands, requester i at bits [2i+1:2i].
REQ-008 SHALL have port req_arg  input  WIDTH*NREQ  packed arguments: load value or step count.
REQ-009 SHALL have port busy  output  1  high while a command is owned (states EXEC, DONE).
REQ-010 SHALL have port grant_id  output  clog2(NREQ)  index of current/last owner.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port done_sat  output  1  valid with done; command stopped at a bound (macro build only, else 0).
REQ-013 SHALL have port count  output  WIDTH  shared counter value.

Function
REQ-014 SHALL use command encoding 00 NOP, 01 LOAD, 10 UP, 11 DOWN.
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with any valid, assert req_ready for exactly one requester, chosen round-robin starting at last grant + 1 (modulo NREQ).
REQ-017 SHALL treat ready as combinational, asserted in IDLE only; handshake = valid & ready on the same edge.
REQ-018 SHALL register the winner's cmd, arg and index at handshake and enter EXEC next cycle.
REQ-019 SHALL complete LOAD in one EXEC cycle; count = arg after that edge.
REQ-020 SHALL execute UP/DOWN as arg EXEC cycles, each cycle stepping count by +1/-1.
REQ-021 SHALL treat arg = 0 for UP/DOWN, and any NOP, as one EXEC cycle with no counter change.
REQ-022 SHALL pulse done for exactly the DONE cycle, with grant_id holding the owner.
REQ-023 SHALL hold count whenever the counter is not loading or stepping.
REQ-024 SHALL ignore valid changes from non-owners while busy; requesters hold valid until ready.
REQ-025 SHALL accept the next command in the IDLE cycle following DONE (min 3 cycles per command).
REQ-026 SHALL update the round-robin pointer only on handshake.

Reset
REQ-027 SHALL, on rst, force state IDLE, count 0, done 0, done_sat 0, grant_id 0, req_ready 0, pointer such that requester 0 has highest priority.
REQ-028 SHALL abort any in-flight command on rst with no done pulse; rst has priority over all other events.

Configuration
REQ-029 SHALL honour macro CNT_SCHED_SATURATE_EN.
REQ-030 SHALL, with CNT_SCHED_SATURATE_EN defined, end UP at 2^WIDTH-1 and DOWN at 0: remaining steps dropped, enter DONE, done_sat = 1.
REQ-031 SHALL, without the macro, wrap modulo 2^WIDTH (F->0, 0->F for WIDTH 4) and tie done_sat to 0.

Structure
REQ-032 SHALL place the command encoding enum and FSM state enum in shared package cnt_sched_pkg.
REQ-033 SHALL instantiate one sub-module cnt_core: WIDTH-bit up/down counter with rst, enable, up_down, load, load_value, count; load overriding enable.
REQ-034 SHALL keep the arbiter, FSM and step counter in counter_scheduler.

Verification
REQ-035 SHALL check reset: rst mid-UP with arg 5 -> count 0, IDLE, no done, requester 0 wins next.
REQ-036 SHALL check LOAD: req 2 LOAD 9 from IDLE -> ready[2] 1 cycle, count = 9 after EXEC, done one cycle later.
REQ-037 SHALL check round-robin: all four valid with NOP -> grants 0,1,2,3,0 in order, one per 3 cycles.
REQ-038 SHALL check stepping: count 3, UP arg 4 -> count 4,5,6,7 on consecutive cycles, then done; DOWN arg 0 -> count unchanged, done.
REQ-039 SHALL check the bound: count E, UP arg 3 -> without macro E,F,0,1; with macro E,F, done_sat 1 after 1 step.
REQ-040 SHALL check that valid asserted while busy -> ready stays 0 until IDLE.
